lsu_ctrl: RTL and testbench
===========================

Name: lsu_ctrl

Overview:
- Load/store sequencer for the MEM stage of the pipelined RV32I core.
- Takes the MemRead/MemWrite controls, funct3, address and store data from EX/MEM, and runs a valid/ready transaction on the data-memory port.
- Generates byte enables, store-data lane replication and load extension.
- Stalls the pipeline until the access completes or times out.

Parameters:
TIMEOUT, 255, max cycles spent in REQ+RESP before the access is aborted with bus_err_o (range 2..65535)

Ports:
clk  in  1  core clock, rising edge
rst  in  1  reset, asynchronous, active-high
mem_read_i  in  1  load request (MemRead from decode, held by pipeline while stalled)
mem_write_i  in  1  store request (MemWrite)
funct3_i  in  3  access size/sign: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu; stores use 000/001/010
addr_i  in  32  byte address (ALU result)
wdata_i  in  32  store data (rs2)
dmem_req_o  out  1  request valid
dmem_we_o  out  1  1 = write
dmem_addr_o  out  32  word address, {addr[31:2],2'b00}
dmem_be_o  out  4  byte enables
dmem_wdata_o  out  32  lane-replicated store data
dmem_ready_i  in  1  memory accepts the request this cycle
dmem_rvalid_i  in  1  read data valid
dmem_rdata_i  in  32  read word
stall_o  out  1  hold IF/ID/EX/MEM
done_o  out  1  one-cycle completion pulse
rdata_o  out  32  extended load result, valid while done_o=1
bus_err_o  out  1  timeout abort, valid while done_o=1
misalign_o  out  1  misaligned access flag (tied 0 unless LSU_MISALIGN_TRAP_EN)

Behaviour:
- Reset: async, active-high. Forces IDLE; all outputs 0; timeout counter 0. If asserted mid-transaction, dmem_req_o drops immediately and the transaction is abandoned.
- FSM states: IDLE, REQ, RESP, DONE.
- IDLE:
  - On mem_read_i or mem_write_i, latch op, funct3, addr and wdata, then go to REQ.
  - If both are asserted, the access is treated as a read.
- REQ:
  - Drive dmem_req_o=1 with dmem_we_o/addr/be/wdata from the latched values, held stable until accepted.
  - On dmem_ready_i: a store goes to DONE (complete on acceptance); a load goes to RESP.
- RESP: wait for dmem_rvalid_i (never sampled in the acceptance cycle). On rvalid, capture the extended data and go to DONE.
- DONE: done_o=1 and stall_o=0 for exactly one cycle, then IDLE.
- stall_o = (IDLE & (mem_read_i|mem_write_i)) | REQ | RESP. It is combinational, so there is no bubble before the stall.
- Minimum latency, zero-wait memory:
  - store: detect cycle + 1 REQ cycle + DONE = 3 cycles.
  - load: detect + REQ + RESP + DONE = 4 cycles.
- Timeout:
  - The counter clears on entering REQ and increments each cycle in REQ/RESP.
  - When it reaches TIMEOUT-1 without completion, go to DONE with bus_err_o=1, rdata_o=0, and dmem_req_o dropped.
- Byte enables:
  - byte: 4'b0001 << addr[1:0].
  - half: 4'b0011 << {addr[1],1'b0}.
  - word: 4'b1111.
  - Loads drive the same be pattern.
- Store data: byte replicated x4; half replicated x2; word as-is.
- Load extraction: select the lane by addr[1:0] (half by addr[1]).
  - lb/lh sign-extend; lbu/lhu zero-extend; lw passes the word.
  - funct3 011/110/111 are treated as lw.
- Misalignment: half with addr[0]=1, or word with addr[1:0]!=0.

Optional Feature:
LSU_MISALIGN_TRAP_EN
- Defined:
  - A misaligned access goes IDLE->DONE directly with no dmem_req_o.
  - done_o=1, misalign_o=1 and rdata_o=0 in DONE.
  - stall_o is high for the single IDLE detect cycle.
- Undefined:
  - misalign_o is constant 0.
  - Misaligned accesses proceed with the offending low address bits ignored: the half uses addr[1] only; the word uses be=1111 at the aligned address.

Test Plan:
- Store: sw addr=0x104, wdata=0xDEADBEEF, ready immediate -> dmem_be_o=1111, addr 0x104, done_o on the 3rd cycle; stall_o high exactly 2 cycles.
- Load extend: lb addr=0x203 with rdata=0x80FF1234 -> rdata_o=0xFFFFFF80; lbu same -> 0x00000080; lhu addr=0x202 -> 0x000080FF.
- Wait states: sb addr=0x11, wdata=0x000000AB, ready after 3 cycles -> be=0010, wdata_o=0xABABABAB held stable, dmem_req_o high 4 cycles, then done_o.
- Timeout: TIMEOUT=8, lw where rvalid never arrives -> done_o with bus_err_o=1 and rdata_o=0 after 8 REQ/RESP cycles; dmem_req_o drops.
- Reset mid-RESP: assert rst while waiting for rvalid -> all outputs 0 asynchronously; the next lw after reset completes normally in 4 cycles.
- Misaligned lw addr=0x102:
  - with LSU_MISALIGN_TRAP_EN -> no dmem_req_o, done_o=misalign_o=1 on cycle 2.
  - without it -> access at 0x100, be=1111.

Source files
------------

// File: rtl/lsu_ctrl.sv
`timescale 1ns/1ps
// MEM-stage load/store sequencer: valid/ready data-memory access, byte lanes, load extension, timeout.
// Optional build macro LSU_MISALIGN_TRAP_EN: misaligned accesses skip the bus and flag misalign_o.
//
// state | meaning
// IDLE  | waiting for mem_read_i / mem_write_i
// REQ   | dmem_req_o held with latched address/enables/data until dmem_ready_i
// RESP  | load accepted, waiting for dmem_rvalid_i
// DONE  | one-cycle completion pulse (done_o), pipeline released
module lsu_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [3:0]  dmem_be_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_ready_i,
  input  logic        dmem_rvalid_i,
  input  logic [31:0] dmem_rdata_i,
  output logic        stall_o,
  output logic        done_o,
  output logic [31:0] rdata_o,
  output logic        bus_err_o,
  output logic        misalign_o
);

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

  localparam logic [15:0] LAST = 16'(TIMEOUT - 1);

  state_t      state;
  logic        is_rd;
  logic [2:0]  f3_q;
  logic [1:0]  lo_q;
  logic [15:0] cnt;
  logic        mis_q;
  logic        trap;
  logic [3:0]  be_in;
  logic [31:0] wd_in;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] ext;

  always_comb begin
    be_in = 4'b1111;
    wd_in = wdata_i;
    case (funct3_i[1:0])
      2'b00: begin
        be_in = 4'b0001 << addr_i[1:0];
        wd_in = {4{wdata_i[7:0]}};
      end
      2'b01: begin
        be_in = 4'b0011 << {addr_i[1], 1'b0};
        wd_in = {2{wdata_i[15:0]}};
      end
      default: ;
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  assign trap = ((funct3_i[1:0] == 2'b01) & addr_i[0]) | (funct3_i[1] & (|addr_i[1:0]));
`else
  assign trap = 1'b0;
`endif

  always_comb begin
    lane_b = dmem_rdata_i[7:0];
    case (lo_q)
      2'd1:    lane_b = dmem_rdata_i[15:8];
      2'd2:    lane_b = dmem_rdata_i[23:16];
      2'd3:    lane_b = dmem_rdata_i[31:24];
      default: lane_b = dmem_rdata_i[7:0];
    endcase
    lane_h = lo_q[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
    case (f3_q)
      3'b000:  ext = {{24{lane_b[7]}}, lane_b};
      3'b001:  ext = {{16{lane_h[15]}}, lane_h};
      3'b100:  ext = {24'd0, lane_b};
      3'b101:  ext = {16'd0, lane_h};
      default: ext = dmem_rdata_i;
    endcase
  end

  // Combinational so the pipeline freezes in the same cycle the access is seen.
  assign stall_o = ((state == IDLE) && (mem_read_i || mem_write_i)) ||
                   (state == REQ) || (state == RESP);

  assign misalign_o = mis_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      is_rd        <= 1'b0;
      f3_q         <= 3'd0;
      lo_q         <= 2'd0;
      cnt          <= 16'd0;
      mis_q        <= 1'b0;
      dmem_req_o   <= 1'b0;
      dmem_we_o    <= 1'b0;
      dmem_addr_o  <= 32'd0;
      dmem_be_o    <= 4'd0;
      dmem_wdata_o <= 32'd0;
      done_o       <= 1'b0;
      rdata_o      <= 32'd0;
      bus_err_o    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_read_i || mem_write_i) begin
            is_rd <= mem_read_i;
            f3_q  <= funct3_i;
            lo_q  <= addr_i[1:0];
            cnt   <= 16'd0;
            if (trap) begin
              state   <= DONE;
              done_o  <= 1'b1;
              mis_q   <= 1'b1;
              rdata_o <= 32'd0;
            end else begin
              state        <= REQ;
              dmem_req_o   <= 1'b1;
              dmem_we_o    <= ~mem_read_i;
              dmem_addr_o  <= {addr_i[31:2], 2'b00};
              dmem_be_o    <= be_in;
              dmem_wdata_o <= mem_read_i ? 32'd0 : wd_in;
            end
          end
        end
        REQ: begin
          cnt <= cnt + 16'd1;
          if (dmem_ready_i || (cnt == LAST)) begin
            dmem_req_o   <= 1'b0;
            dmem_we_o    <= 1'b0;
            dmem_addr_o  <= 32'd0;
            dmem_be_o    <= 4'd0;
            dmem_wdata_o <= 32'd0;
          end
          // A store completes on acceptance, even in the last allowed cycle.
          if (dmem_ready_i && !is_rd) begin
            state   <= DONE;
            done_o  <= 1'b1;
            rdata_o <= 32'd0;
          end else if (cnt == LAST) begin
            state     <= DONE;
            done_o    <= 1'b1;
            bus_err_o <= 1'b1;
            rdata_o   <= 32'd0;
          end else if (dmem_ready_i) begin
            state <= RESP;
          end
        end
        RESP: begin
          cnt <= cnt + 16'd1;
          if (dmem_rvalid_i) begin
            state   <= DONE;
            done_o  <= 1'b1;
            rdata_o <= ext;
          end else if (cnt == LAST) begin
            state     <= DONE;
            done_o    <= 1'b1;
            bus_err_o <= 1'b1;
            rdata_o   <= 32'd0;
          end
        end
        DONE: begin
          state     <= IDLE;
          done_o    <= 1'b0;
          bus_err_o <= 1'b0;
          mis_q     <= 1'b0;
          rdata_o   <= 32'd0;
          cnt       <= 16'd0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
`timescale 1ns/1ps
// Directed bench for lsu_ctrl (TIMEOUT=8): latency, lanes, extension, wait states, timeout, reset.
module tb_lsu_ctrl;

  logic        clk;
  logic        rst;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [3:0]  dmem_be_o;
  logic [31:0] dmem_wdata_o;
  logic        ready;
  logic        rvalid;
  logic [31:0] rdata_in;
  logic        stall_o;
  logic        done_o;
  logic [31:0] rdata_o;
  logic        bus_err_o;
  logic        misalign_o;

  int n_checks = 0;
  int n_err    = 0;

  int          r_cyc, r_stall, r_req;
  logic [31:0] r_addr, r_wdata, r_rdata;
  logic [3:0]  r_be;
  logic        r_we, r_err, r_mis, r_stable, r_req_at_done;

  lsu_ctrl #(.TIMEOUT(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .mem_read_i   (mem_read),
    .mem_write_i  (mem_write),
    .funct3_i     (funct3),
    .addr_i       (addr),
    .wdata_i      (wdata),
    .dmem_req_o   (dmem_req_o),
    .dmem_we_o    (dmem_we_o),
    .dmem_addr_o  (dmem_addr_o),
    .dmem_be_o    (dmem_be_o),
    .dmem_wdata_o (dmem_wdata_o),
    .dmem_ready_i (ready),
    .dmem_rvalid_i(rvalid),
    .dmem_rdata_i (rdata_in),
    .stall_o      (stall_o),
    .done_o       (done_o),
    .rdata_o      (rdata_o),
    .bus_err_o    (bus_err_o),
    .misalign_o   (misalign_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Entered at posedge+1 with the DUT idle. ready comes after rdy_dly wait cycles,
  // rvalid rv_dly cycles after acceptance (negative = never).
  task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] wd,
                            input int rdy_dly, input int rv_dly, input logic [31:0] rword);
    int resp_n;
    bit acc;
    r_cyc = 0; r_stall = 0; r_req = 0; r_stable = 1'b1; r_rdata = 32'd0;
    r_err = 1'b0; r_mis = 1'b0; r_req_at_done = 1'b0;
    r_addr = 32'd0; r_wdata = 32'd0; r_be = 4'd0; r_we = 1'b0;
    acc = 1'b0; resp_n = 0;
    mem_read = rd; mem_write = wr; funct3 = f3; addr = a; wdata = wd; rdata_in = rword;
    ready = 1'b0; rvalid = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (dmem_req_o) begin
        r_req++;
        if (r_req == 1) begin
          r_addr = dmem_addr_o; r_be = dmem_be_o; r_wdata = dmem_wdata_o; r_we = dmem_we_o;
        end else if (dmem_addr_o !== r_addr || dmem_be_o !== r_be ||
                     dmem_wdata_o !== r_wdata || dmem_we_o !== r_we) begin
          r_stable = 1'b0;
        end
        ready = (r_req > rdy_dly);
      end else begin
        ready = 1'b0;
      end
      rvalid = acc && (rv_dly >= 0) && (resp_n == rv_dly);
      #1;
      if (stall_o) r_stall++;
      if (done_o) begin
        r_cyc = c; r_rdata = rdata_o; r_err = bus_err_o; r_mis = misalign_o;
        r_req_at_done = dmem_req_o;
        break;
      end
      if (acc) resp_n++;
      if (dmem_req_o && ready) acc = 1'b1;
      @(posedge clk); #1;
    end
    mem_read = 1'b0; mem_write = 1'b0; ready = 1'b0; rvalid = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'd0; addr = 32'd0;
    wdata = 32'd0; ready = 1'b0; rvalid = 1'b0; rdata_in = 32'd0;
    #12;
    check("rst_req",   dmem_req_o, 0);
    check("rst_done",  done_o,     0);
    check("rst_stall", stall_o,    0);
    check("rst_be",    dmem_be_o,  0);
    check("rst_rdata", rdata_o,    0);
    check("rst_err",   bus_err_o,  0);
    check("rst_mis",   misalign_o, 0);
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1;

    // sw zero-wait
    run_access(1'b0, 1'b1, 3'b010, 32'h104, 32'hDEADBEEF, 0, -1, 32'd0);
    check("sw_cyc",   r_cyc,   3);
    check("sw_stall", r_stall, 2);
    check("sw_req",   r_req,   1);
    check("sw_addr",  r_addr,  32'h104);
    check("sw_be",    r_be,    4'b1111);
    check("sw_wdata", r_wdata, 32'hDEADBEEF);
    check("sw_we",    r_we,    1);
    check("sw_err",   r_err,   0);
    check("sw_done_clear", done_o, 0);

    // load extension
    run_access(1'b1, 1'b0, 3'b000, 32'h203, 32'd0, 0, 0, 32'h80FF1234);
    check("lb_cyc",   r_cyc,   4);
    check("lb_stall", r_stall, 3);
    check("lb_addr",  r_addr,  32'h200);
    check("lb_be",    r_be,    4'b1000);
    check("lb_we",    r_we,    0);
    check("lb_data",  r_rdata, 32'hFFFFFF80);
    run_access(1'b1, 1'b0, 3'b100, 32'h203, 32'd0, 0, 0, 32'h80FF1234);
    check("lbu_data", r_rdata, 32'h00000080);
    run_access(1'b1, 1'b0, 3'b101, 32'h202, 32'd0, 0, 0, 32'h80FF1234);
    check("lhu_data", r_rdata, 32'h000080FF);
    check("lhu_be",   r_be,    4'b1100);
    run_access(1'b1, 1'b0, 3'b001, 32'h202, 32'd0, 0, 0, 32'h80FF1234);
    check("lh_hi",    r_rdata, 32'hFFFF80FF);
    run_access(1'b1, 1'b0, 3'b001, 32'h200, 32'd0, 0, 0, 32'h80FF1234);
    check("lh_lo",    r_rdata, 32'h00001234);
    check("lh_lo_be", r_be,    4'b0011);
    run_access(1'b1, 1'b0, 3'b000, 32'h201, 32'd0, 0, 0, 32'h80FF1234);
    check("lb_b1",    r_rdata, 32'h00000012);
    run_access(1'b1, 1'b0, 3'b010, 32'h200, 32'd0, 0, 2, 32'h80FF1234);
    check("lw_slow_cyc",  r_cyc,   6);
    check("lw_slow_data", r_rdata, 32'h80FF1234);
    run_access(1'b1, 1'b0, 3'b011, 32'h200, 32'd0, 0, 0, 32'h80FF1234);
    check("f3_011_data", r_rdata, 32'h80FF1234);
    run_access(1'b1, 1'b0, 3'b110, 32'h200, 32'd0, 0, 0, 32'h80FF1234);
    check("f3_110_data", r_rdata, 32'h80FF1234);

    // sb with 3 wait states
    run_access(1'b0, 1'b1, 3'b000, 32'h11, 32'h000000AB, 3, -1, 32'd0);
    check("sb_be",     r_be,     4'b0010);
    check("sb_wdata",  r_wdata,  32'hABABABAB);
    check("sb_addr",   r_addr,   32'h10);
    check("sb_req",    r_req,    4);
    check("sb_stable", r_stable, 1);
    check("sb_cyc",    r_cyc,    6);
    run_access(1'b0, 1'b1, 3'b001, 32'h102, 32'h1234BEEF, 0, -1, 32'd0);
    check("sh_be",    r_be,    4'b1100);
    check("sh_wdata", r_wdata, 32'hBEEFBEEF);

    // read and write together act as a read
    run_access(1'b1, 1'b1, 3'b010, 32'h40, 32'h55555555, 0, 0, 32'h0BADCAFE);
    check("rw_we",   r_we,    0);
    check("rw_cyc",  r_cyc,   4);
    check("rw_data", r_rdata, 32'h0BADCAFE);

    // timeouts
    run_access(1'b1, 1'b0, 3'b010, 32'h80, 32'd0, 0, -1, 32'h12345678);
    check("to_ld_cyc",   r_cyc,         10);
    check("to_ld_err",   r_err,         1);
    check("to_ld_data",  r_rdata,       0);
    check("to_ld_req",   r_req_at_done, 0);
    run_access(1'b0, 1'b1, 3'b010, 32'h84, 32'h1, 100, -1, 32'd0);
    check("to_st_cyc",   r_cyc,         10);
    check("to_st_reqn",  r_req,         8);
    check("to_st_err",   r_err,         1);
    check("to_st_req",   r_req_at_done, 0);
    run_access(1'b1, 1'b0, 3'b010, 32'h80, 32'd0, 0, 0, 32'h12345678);
    check("post_to_cyc", r_cyc,   4);
    check("post_to_err", r_err,   0);
    check("post_to_dat", r_rdata, 32'h12345678);

    // misaligned
    run_access(1'b1, 1'b0, 3'b010, 32'h102, 32'd0, 0, 0, 32'hA5A5F00F);
`ifdef LSU_MISALIGN_TRAP_EN
    check("mis_req",   r_req,   0);
    check("mis_cyc",   r_cyc,   2);
    check("mis_flag",  r_mis,   1);
    check("mis_data",  r_rdata, 0);
    check("mis_stall", r_stall, 1);
`else
    check("mis_addr",  r_addr,  32'h100);
    check("mis_be",    r_be,    4'b1111);
    check("mis_flag",  r_mis,   0);
    check("mis_cyc",   r_cyc,   4);
    check("mis_data",  r_rdata, 32'hA5A5F00F);
    run_access(1'b1, 1'b0, 3'b001, 32'h201, 32'd0, 0, 0, 32'h80FF1234);
    check("mis_lh_be",   r_be,    4'b0011);
    check("mis_lh_data", r_rdata, 32'h00001234);
`endif

    // reset while in REQ (ph=0) and in RESP (ph=1)
    for (int ph = 0; ph < 2; ph++) begin
      mem_read = 1'b1; funct3 = 3'b010; addr = 32'h300; ready = 1'b0; rvalid = 1'b0;
      @(posedge clk); #1;
      check("rst_pre_req", dmem_req_o, 1);
      ready = (ph == 1);
      @(posedge clk); #1;
      ready = 1'b0;
      #2;
      rst = 1'b1; mem_read = 1'b0;
      #1;
      check("arst_req",   dmem_req_o,  0);
      check("arst_stall", stall_o,     0);
      check("arst_done",  done_o,      0);
      check("arst_be",    dmem_be_o,   0);
      check("arst_addr",  dmem_addr_o, 0);
      @(posedge clk); #1; rst = 1'b0;
      @(posedge clk); #1;
      run_access(1'b1, 1'b0, 3'b010, 32'h300, 32'd0, 0, 0, 32'hCAFEF00D);
      check("post_rst_cyc",  r_cyc,   4);
      check("post_rst_data", r_rdata, 32'hCAFEF00D);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
